alu_share_arbiter: RTL

//  Shares one combinational 32-bit ALU between two requesters: req 0 = core

---
 rtl/alu_share_arbiter.sv | 130 +++++++++++++
 1 files changed

// File: rtl/alu_share_arbiter.sv
// Time-shares one combinational ALU between two valid/ready requesters.
// Each op takes three states: accept in IDLE, one EXEC cycle, then hold the response in RESP.
module alu_share_arbiter #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      req_valid,
  output logic [1:0]      req_ready,
  input  logic [XLEN-1:0] req_srcA_0,
  input  logic [XLEN-1:0] req_srcB_0,
  input  logic [2:0]      req_op_0,
  input  logic [XLEN-1:0] req_srcA_1,
  input  logic [XLEN-1:0] req_srcB_1,
  input  logic [2:0]      req_op_1,
  output logic [1:0]      rsp_valid,
  input  logic [1:0]      rsp_ready,
  output logic [XLEN-1:0] rsp_result,
  output logic            rsp_zero,
  output logic            rsp_sign,
  output logic            rsp_err,
  output logic [XLEN-1:0] alu_srcA,
  output logic [XLEN-1:0] alu_srcB,
  output logic [2:0]      alu_ctrl,
  input  logic [XLEN-1:0] alu_result,
  input  logic            alu_zero,
  input  logic            alu_sign
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e          state_q, state_d;
  logic            ptr_q, ptr_d;
  logic            gnt_q;
  logic            gnt;
  logic            accept;
  logic            complete;
  logic [XLEN-1:0] srca_q, srcb_q, res_q;
  logic [2:0]      op_q;
  logic            err_q, zero_q, sign_q;

  // Pointer only breaks ties; a lone requester always wins.
  always_comb begin
    gnt = 1'b0;
    if (req_valid == 2'b11) begin
      gnt = (FIXED_PRIO != 0) ? 1'b0 : ptr_q;
    end else begin
      gnt = ~req_valid[0];
    end
  end

  always_comb begin
    req_ready = 2'b00;
    if (state_q == StIdle && req_valid != 2'b00) begin
      req_ready[gnt] = 1'b1;
    end
  end

  assign accept   = (state_q == StIdle) && ((req_valid & req_ready) != 2'b00);
  assign complete = (state_q == StResp) && rsp_ready[gnt_q];

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      StIdle: if (accept) state_d = StExec;
      StExec: state_d = StResp;
      StResp: begin
        if (complete) begin
          state_d = StIdle;
          if (FIXED_PRIO == 0) ptr_d = ~gnt_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    rsp_valid = 2'b00;
    if (state_q == StResp) rsp_valid[gnt_q] = 1'b1;
  end

  assign rsp_result = res_q;
  assign rsp_zero   = zero_q;
  assign rsp_sign   = sign_q;
  assign rsp_err    = err_q;

  // The ALU sees zeros outside EXEC so downstream toggling stays quiet.
  assign alu_srcA = (state_q == StExec) ? srca_q : '0;
  assign alu_srcB = (state_q == StExec) ? srcb_q : '0;
  assign alu_ctrl = (state_q == StExec) ? op_q : 3'b000;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ptr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q  <= 1'b0;
      srca_q <= '0;
      srcb_q <= '0;
      op_q   <= 3'b000;
      err_q  <= 1'b0;
      res_q  <= '0;
      zero_q <= 1'b0;
      sign_q <= 1'b0;
    end else begin
      if (accept) begin
        gnt_q  <= gnt;
        srca_q <= gnt ? req_srcA_1 : req_srcA_0;
        srcb_q <= gnt ? req_srcB_1 : req_srcB_0;
        op_q   <= gnt ? req_op_1 : req_op_0;
        err_q  <= (gnt ? req_op_1 : req_op_0) == 3'b011;
      end
      if (state_q == StExec) begin
        res_q  <= alu_result;
        zero_q <= alu_zero;
        sign_q <= alu_sign;
      end
    end
  end

endmodule
